// File: rtl/sysbus_arbiter_pkg.sv
// Shared constants, FSM encoding and a width helper for the system-bus arbiter.
package sysbus_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Both handshakes are active-low on the wire.
  localparam logic STRB_ACTIVE = 1'b0;
  localparam logic RDY_ACTIVE  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled with modports.
interface sysbus_arbiter_if
  import sysbus_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Handshake: a requester pulses m_strb[i] low for one cycle with m_rw/m_addr/m_wdata
  // valid on that edge; the arbiter answers with exactly one m_rdy[i] low pulse
  // (m_err[i] high on the same cycle if memory timed out), m_rdata valid during it.
  // On the memory side sstrb low for one cycle starts a transfer; srdy low for one
  // cycle while the arbiter waits ends it, srdata valid with srdy.
  logic [NREQ-1:0]        m_strb;
  logic [NREQ-1:0]        m_rw;
  logic [NREQ*ADDR_W-1:0] m_addr;
  logic [NREQ*DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0]      m_rdata;
  logic [NREQ-1:0]        m_rdy;
  logic [NREQ-1:0]        m_err;
  logic [ADDR_W-1:0]      saddr;
  logic [DATA_W-1:0]      swdata;
  logic [DATA_W-1:0]      srdata;
  logic                   srw;
  logic                   sstrb;
  logic                   srdy;
  logic                   busy;

  modport slave (
    input  m_strb, m_rw, m_addr, m_wdata, srdata, srdy,
    output m_rdata, m_rdy, m_err, saddr, swdata, srw, sstrb, busy
  );

  modport master (
    output m_strb, m_rw, m_addr, m_wdata, srdata, srdy,
    input  m_rdata, m_rdy, m_err, saddr, swdata, srw, sstrb, busy
  );

endinterface

// File: rtl/sysbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending slot at or above the pointer, wrapping.
module sysbus_arbiter_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  always_comb begin
    logic [IDX_W:0] cand;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr+k cannot overflow before the modulo fold.
      cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!any_o && pending_i[cand[IDX_W-1:0]]) begin
        any_o                           = 1'b1;
        grant_idx_o                     = cand[IDX_W-1:0];
        grant_oh_o[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one memory bus among NREQ strobe/ready requesters,
// with per-slot request latching and a saturating transaction timeout.
module sysbus_arbiter
  import sysbus_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic   clk,
  input  logic   rst_n,
  sysbus_arbiter_if.slave bus,
  output state_t state_o
);

  localparam int IDX_W = idx_w(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]    pending_q, pending_d;
  logic [NREQ-1:0]    clr;

  logic [NREQ-1:0]    slot_rw_q, slot_rw_d;
  logic [ADDR_W-1:0]  slot_addr_q  [NREQ];
  logic [ADDR_W-1:0]  slot_addr_d  [NREQ];
  logic [DATA_W-1:0]  slot_wdata_q [NREQ];
  logic [DATA_W-1:0]  slot_wdata_d [NREQ];

  logic [ADDR_W-1:0]  saddr_q, saddr_d;
  logic [DATA_W-1:0]  swdata_q, swdata_d;
  logic               srw_q, srw_d;
  logic               sstrb_q, sstrb_d;
  logic [NREQ-1:0]    m_rdy_q, m_rdy_d;
  logic [NREQ-1:0]    m_err_q, m_err_d;
  logic [DATA_W-1:0]  m_rdata_q, m_rdata_d;

  logic [NREQ-1:0]    pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  sysbus_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending_i   (pending_q),
    .ptr_i       (ptr_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  // Request capture; a strobe landing on its own completion edge re-arms the slot.
  always_comb begin
    pending_d    = pending_q;
    slot_rw_d    = slot_rw_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    for (int i = 0; i < NREQ; i++) begin
      if ((bus.m_strb[i] == STRB_ACTIVE) && (!pending_q[i] || clr[i])) begin
        pending_d[i]    = 1'b1;
        slot_rw_d[i]    = bus.m_rw[i];
        slot_addr_d[i]  = bus.m_addr[i*ADDR_W +: ADDR_W];
        slot_wdata_d[i] = bus.m_wdata[i*DATA_W +: DATA_W];
      end else if (clr[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    saddr_d   = saddr_q;
    swdata_d  = swdata_q;
    srw_d     = srw_q;
    sstrb_d   = ~STRB_ACTIVE;
    m_rdy_d   = {NREQ{~RDY_ACTIVE}};
    m_err_d   = '0;
    m_rdata_d = '0;
    clr       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_oh;
          ptr_d    = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          saddr_d  = slot_addr_q[pick_idx];
          swdata_d = slot_wdata_q[pick_idx];
          srw_d    = slot_rw_q[pick_idx];
          sstrb_d  = STRB_ACTIVE;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.srdy == RDY_ACTIVE) begin
          m_rdy_d   = ~gnt_q;
          m_rdata_d = bus.srdata;
          clr       = gnt_q;
          state_d   = ST_IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          m_rdy_d = ~gnt_q;
          m_err_d = gnt_q;
          clr     = gnt_q;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      slot_rw_q <= '0;
      saddr_q   <= '0;
      swdata_q  <= '0;
      srw_q     <= 1'b0;
      sstrb_q   <= ~STRB_ACTIVE;
      m_rdy_q   <= {NREQ{~RDY_ACTIVE}};
      m_err_q   <= '0;
      m_rdata_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_addr_q[i]  <= '0;
        slot_wdata_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      slot_rw_q    <= slot_rw_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      saddr_q      <= saddr_d;
      swdata_q     <= swdata_d;
      srw_q        <= srw_d;
      sstrb_q      <= sstrb_d;
      m_rdy_q      <= m_rdy_d;
      m_err_q      <= m_err_d;
      m_rdata_q    <= m_rdata_d;
    end
  end

  assign bus.saddr   = saddr_q;
  assign bus.swdata  = swdata_q;
  assign bus.srw     = srw_q;
  assign bus.sstrb   = sstrb_q;
  assign bus.m_rdy   = m_rdy_q;
  assign bus.m_err   = m_err_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: stimulus thread plays requesters and memory,
// a monitor thread checks bus strobes and completions against expected queues.
module tb_sysbus_arbiter;
  import sysbus_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int TOUT = 64;
  localparam int BW   = 1 + AW + DW;      // bus item {rw, addr, wdata}
  localparam int RW   = 3 + 1 + DW + 8;   // response item {idx, err, rdata, latency}

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  sysbus_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sysbus_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] bus_q[$];
  logic [RW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int strb_seen = 0;
  int last_strb_cyc = 0;
  int resp_cnt [NREQ];
  int issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  task automatic expect_txn(input int idx, input logic rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic err,
                            input logic [DW-1:0] rd, input int lat);
    bus_q.push_back({rw, a, wd});
    exp_q.push_back({3'(idx), err, rd, 8'(lat)});
  endtask

  // Monitor: every bus strobe and every completion pulse is matched to the queues.
  initial begin
    for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.sstrb === 1'b0) begin
          strb_seen++;
          last_strb_cyc = cyc;
          if (bus_q.size() == 0) begin
            n_total++;
            $display("FAIL bus_unexpected: got strobe addr 0x%0h, required no strobe", bus.saddr);
          end else begin
            logic [BW-1:0] b;
            b = bus_q.pop_front();
            check("bus_txn", 32'({bus.srw, bus.saddr, bus.swdata}), 32'(b));
          end
        end
        if (bus.m_rdy !== 4'hF) begin
          for (int i = 0; i < NREQ; i++) if (bus.m_rdy[i] === 1'b0) resp_cnt[i]++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL rdy_unexpected: got m_rdy 0x%0h, required 0xf", bus.m_rdy);
          end else begin
            logic [RW-1:0] e;
            logic [3:0]    er;
            logic [3:0]    ee;
            int            idx;
            e   = exp_q.pop_front();
            idx = int'(e[RW-1 -: 3]);
            er  = 4'hF;
            er[idx] = 1'b0;
            ee  = 4'h0;
            if (e[RW-4]) ee[idx] = 1'b1;
            check("m_rdy", 32'(bus.m_rdy), 32'(er));
            check("m_err", 32'(bus.m_err), 32'(ee));
            check("m_rdata", 32'(bus.m_rdata), 32'(e[DW+7:8]));
            if (e[7:0] != 8'd0) check("latency", 32'(cyc - last_strb_cyc), 32'(e[7:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic stage(input int idx, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.m_rw[idx]             = rw;
    bus.m_addr[idx*AW +: AW]  = a;
    bus.m_wdata[idx*DW +: DW] = wd;
  endtask

  task automatic fire(input logic [NREQ-1:0] mask);
    bus.m_strb = ~mask;
    @(negedge clk);
    bus.m_strb = '1;
  endtask

  // Memory side: wait for a strobe, answer after 'delay' cycles (negative = never).
  task automatic serve(input int delay, input logic fixed, input logic [DW-1:0] fixed_data,
                       input logic restrobe);
    int n;
    logic [AW-1:0] a;
    logic [1:0]    g;
    n = 0;
    while (bus.sstrb !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.sstrb !== 1'b0) begin
      n_total++;
      $display("FAIL sstrb_wait: got no strobe in %0d cycles, required one", n);
      return;
    end
    a = bus.saddr;
    if (delay < 0) return;
    repeat (delay) @(negedge clk);
    bus.srdy   = 1'b0;
    bus.srdata = fixed ? fixed_data : mem_word(a);
    // Re-strobe the completing requester on its own completion edge.
    if (restrobe && issued < 40) begin
      g = a[1:0];
      stage(int'(g), 1'b1, a + 8'd4, 16'h0);
      bus.m_strb[g] = 1'b0;
      expect_txn(int'(g), 1'b1, a + 8'd4, 16'h0, 1'b0, mem_word(a + 8'd4), 0);
      issued++;
    end
    @(negedge clk);
    bus.srdy   = 1'b1;
    bus.srdata = '0;
    bus.m_strb = '1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int base_cnt [NREQ];
    rst_n       = 1'b0;
    bus.m_strb  = '1;
    bus.m_rw    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.srdata  = '0;
    bus.srdy    = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_sstrb", 32'(bus.sstrb), 32'd1);
    check("rst_saddr", 32'(bus.saddr), 32'd0);
    check("rst_swdata", 32'(bus.swdata), 32'd0);
    check("rst_srw", 32'(bus.srw), 32'd0);
    check("rst_m_rdy", 32'(bus.m_rdy), 32'hF);
    check("rst_m_err", 32'(bus.m_err), 32'd0);
    check("rst_m_rdata", 32'(bus.m_rdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: 0 and 2 on one edge, pointer at 0 so 0 goes first.
    stage(0, 1'b0, 8'h10, 16'h1111);
    stage(2, 1'b0, 8'h22, 16'h2222);
    expect_txn(0, 1'b0, 8'h10, 16'h1111, 1'b0, mem_word(8'h10), 2);
    expect_txn(2, 1'b0, 8'h22, 16'h2222, 1'b0, mem_word(8'h22), 4);
    fire(4'b0101);
    serve(1, 1'b0, 16'h0, 1'b0);
    serve(3, 1'b0, 16'h0, 1'b0);
    drain(50);

    // Single read answered two cycles after the strobe.
    stage(0, 1'b1, 8'h12, 16'h0);
    expect_txn(0, 1'b1, 8'h12, 16'h0, 1'b0, 16'hBEEF, 3);
    fire(4'b0001);
    serve(2, 1'b1, 16'hBEEF, 1'b0);
    drain(50);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // Duplicate strobe from 1 while pending is dropped.
    base = strb_seen;
    stage(1, 1'b1, 8'h21, 16'h0);
    expect_txn(1, 1'b1, 8'h21, 16'h0, 1'b0, mem_word(8'h21), 0);
    fire(4'b0010);
    stage(1, 1'b1, 8'h99, 16'h5555);
    fire(4'b0010);
    serve(1, 1'b0, 16'h0, 1'b0);
    drain(50);
    repeat (5) @(negedge clk);
    check("dup_strobes", 32'(strb_seen - base), 32'd1);

    // Timeout on 2 (memory silent), then 3 proceeds.
    stage(2, 1'b0, 8'hF0, 16'hDEAD);
    stage(3, 1'b1, 8'h33, 16'h0);
    expect_txn(2, 1'b0, 8'hF0, 16'hDEAD, 1'b1, 16'h0, TOUT + 1);
    expect_txn(3, 1'b1, 8'h33, 16'h0, 1'b0, mem_word(8'h33), 0);
    fire(4'b1100);
    serve(-1, 1'b0, 16'h0, 1'b0);
    repeat (10) @(negedge clk);
    check("wait_busy", 32'(bus.busy), 32'd1);
    check("wait_state", 32'(dbg_state), 32'(ST_WAIT));
    serve(1, 1'b0, 16'h0, 1'b0);
    drain(100);

    // Reset while waiting on 0 with 3 still pending.
    stage(0, 1'b1, 8'hF5, 16'h0);
    stage(3, 1'b1, 8'h30, 16'h0);
    bus_q.push_back({1'b1, 8'hF5, 16'h0});
    fire(4'b1001);
    serve(-1, 1'b0, 16'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("dead_bus_seen", 32'(bus_q.size()), 32'd0);
    base = strb_seen;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus_q.delete();
    exp_q.delete();
    #1;
    check("arst_sstrb", 32'(bus.sstrb), 32'd1);
    check("arst_m_rdy", 32'(bus.m_rdy), 32'hF);
    check("arst_m_err", 32'(bus.m_err), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("strobes_after_reset", 32'(strb_seen - base), 32'd0);

    // Fairness: all four re-strobe on their own completion, 40 transactions total.
    for (int i = 0; i < NREQ; i++) begin
      base_cnt[i] = resp_cnt[i];
      stage(i, 1'b1, 8'h40 + 8'(i), 16'h0);
      expect_txn(i, 1'b1, 8'h40 + 8'(i), 16'h0, 1'b0, mem_word(8'h40 + 8'(i)), 0);
    end
    issued = 4;
    fire(4'b1111);
    for (int t = 0; t < 40; t++) serve(1 + (t % 3), 1'b0, 16'h0, 1'b1);
    drain(100);
    for (int i = 0; i < NREQ; i++) check($sformatf("grants_%0d", i), 32'(resp_cnt[i] - base_cnt[i]), 32'd10);

    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
